// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: ALU select codes, MDU state encoding and op classification
package muldiv_unit_pkg;
  localparam int ALU_SEL_W = 5;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL    = 5'd10;
  localparam logic [ALU_SEL_W-1:0] ALU_MULH   = 5'd11;
  localparam logic [ALU_SEL_W-1:0] ALU_MULHSU = 5'd12;
  localparam logic [ALU_SEL_W-1:0] ALU_MULHU  = 5'd13;
  localparam logic [ALU_SEL_W-1:0] ALU_DIV    = 5'd14;
  localparam logic [ALU_SEL_W-1:0] ALU_DIVU   = 5'd15;
  localparam logic [ALU_SEL_W-1:0] ALU_REM    = 5'd16;
  localparam logic [ALU_SEL_W-1:0] ALU_REMU   = 5'd17;
  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_FIN} mdu_state_t;
  function automatic logic is_muldiv(input logic [ALU_SEL_W-1:0] sel);
    return sel >= ALU_MUL && sel <= ALU_REMU;
  endfunction
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc
);
  logic [XLEN-1:0] b_q;
  logic [XLEN:0] sum, rs, diff;
  logic ge;
  // multiply adds b into the high half when the low bit is set; divide trial-subtracts b from the shifted remainder
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    rs = acc[2*XLEN-1:XLEN-1];
    diff = rs - {1'b0, b_q};
    ge = !diff[XLEN];
  end
  // low half holds multiplier / dividend-then-quotient, high half holds partial product / remainder
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      b_q <= '0;
    end else if (load) begin
      acc <= {{XLEN{1'b0}}, a};
      b_q <= b;
    end else if (step) begin
      acc <= is_div ? {ge ? diff[XLEN-1:0] : rs[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with fast paths, kill and done handshake
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ALU_SEL_W-1:0] alu_ctl,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic                 kill,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result
);
  localparam int CW = $clog2(XLEN);
  mdu_state_t state;
  logic [CW-1:0] count;
  logic [ALU_SEL_W-1:0] op;
  logic sa, sb, fast, sa_in, sb_in, dz, ov, accept, is_q_in;
  logic [XLEN-1:0] fast_res, result_q, quo, rem, fin, fp_val, min_v, a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod;
  // input sign/fast-path decode and output sign correction
  always_comb begin
    min_v = {1'b1, {(XLEN-1){1'b0}}};
    accept = state == MDU_IDLE && start && is_muldiv(alu_ctl);
    sa_in = op_a[XLEN-1] && (alu_ctl == ALU_MULH || alu_ctl == ALU_MULHSU || alu_ctl == ALU_DIV || alu_ctl == ALU_REM);
    sb_in = op_b[XLEN-1] && (alu_ctl == ALU_MULH || alu_ctl == ALU_DIV || alu_ctl == ALU_REM);
    a_mag = sa_in ? -op_a : op_a;
    b_mag = sb_in ? -op_b : op_b;
    is_q_in = alu_ctl == ALU_DIV || alu_ctl == ALU_DIVU;
    dz = op_b == '0 && alu_ctl >= ALU_DIV;
    ov = op_a == min_v && op_b == '1 && (alu_ctl == ALU_DIV || alu_ctl == ALU_REM);
    fp_val = dz ? (is_q_in ? '1 : op_a) : (alu_ctl == ALU_DIV ? min_v : '0);
    prod = (sa ^ sb) ? -acc : acc;
    quo = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fin = fast ? fast_res :
          op < ALU_DIV ? (op == ALU_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
          (op == ALU_DIV || op == ALU_DIVU) ? quo : rem;
    busy = state != MDU_IDLE;
    done = state == MDU_FIN && !kill;
    result = done ? fin : result_q;
  end
  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk(clk),
    .reset_n(reset_n),
    .load(accept),
    .step(state == MDU_CALC),
    .is_div(op >= ALU_DIV),
    .a(a_mag),
    .b(b_mag),
    .acc(acc)
  );
  // IDLE -> CALC (or FIN on fast path) -> FIN -> IDLE, kill aborts back to IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= MDU_IDLE;
      count <= '0;
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      fast <= 1'b0;
      fast_res <= '0;
      result_q <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (accept) begin
          op <= alu_ctl;
          sa <= sa_in;
          sb <= sb_in;
          fast <= dz || ov;
          fast_res <= fp_val;
          count <= CW'(XLEN - 1);
          state <= (dz || ov) ? MDU_FIN : MDU_CALC;
        end
        MDU_CALC: if (kill) state <= MDU_IDLE;
        else begin
          count <= count - 1'b1;
          if (count == '0) state <= MDU_FIN;
        end
        MDU_FIN: begin
          state <= MDU_IDLE;
          if (!kill) result_q <= fin;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a result/latency scoreboard checked by a done monitor
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic kill = 1'b0;
  logic [ALU_SEL_W-1:0] alu_ctl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic busy, done;
  logic [31:0] result;
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  typedef struct {string nm; logic [31:0] r; int c;} exp_t;
  exp_t q[$];

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_ctl(alu_ctl),
    .op_a(op_a), .op_b(op_b), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, result, e.r);
        chk({e.nm, "_cycle"}, ecnt, e.c);
      end
    end
  end

  task automatic issue(input string nm, input logic [ALU_SEL_W-1:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit fast, input bit push);
    @(negedge clk);
    start = 1'b1;
    alu_ctl = ctl;
    op_a = a;
    op_b = b;
    if (push) q.push_back('{nm, exp, ecnt + 1 + (fast ? 0 : 32)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 80 && busy; i++) @(negedge clk);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset_n = 1'b1;
    issue("mul", ALU_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 1);
    chk("mul_busy_c1", {31'd0, busy}, 32'd1);
    wait_idle("mul");
    issue("mulh", ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1);
    wait_idle("mulh");
    issue("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    wait_idle("mulhsu");
    issue("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1);
    wait_idle("mulhu");
    issue("div", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 1);
    wait_idle("div");
    issue("rem", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 1);
    wait_idle("rem");
    issue("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 0, 1);
    wait_idle("divu");
    issue("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 0, 1);
    wait_idle("remu");
    issue("divu_z", ALU_DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 1);
    wait_idle("divu_z");
    issue("rem_ov", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1);
    wait_idle("rem_ov");
    issue("div_ov", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    wait_idle("div_ov");
    issue("div_z", ALU_DIV, 32'h5, 32'd0, 32'hFFFFFFFF, 1, 1);
    wait_idle("div_z");
    issue("remu_z", ALU_REMU, 32'h55, 32'd0, 32'h55, 1, 1);
    wait_idle("remu_z");
    issue("killed_div", ALU_DIV, 32'd1000, 32'd3, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done}, 32'd0);
    chk("kill_result", result, 32'h55);
    issue("mul_after_kill", ALU_MUL, 32'd5, 32'd6, 32'd30, 0, 1);
    wait_idle("mul_after_kill");
    issue("mul_busy_start", ALU_MUL, 32'h12345, 32'h10, 32'h123450, 0, 1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    alu_ctl = ALU_DIVU;
    op_a = 32'd9;
    op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mul_busy_start");
    repeat (40) @(negedge clk);
    chk("ignored_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    alu_ctl = ALU_ADD;
    @(negedge clk);
    start = 1'b0;
    chk("alu_add_busy", {31'd0, busy}, 32'd0);
    issue("reset_mul", ALU_MUL, 32'd3, 32'd4, 32'd12, 0, 0);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    issue("mul_after_rst", ALU_MUL, 32'hFFFF, 32'hFFFF, 32'hFFFE0001, 0, 1);
    wait_idle("mul_after_rst");
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
